// File: rtl/median_seq_ctrl.sv
// Sequencing controller for the median-filter datapath: walks each pixel through address fetch,
// RAM-latency-aligned window capture, four comparator stages and a downstream handshake.
module median_seq_ctrl #(
    parameter int unsigned LENGTH = 480,
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_ready,
    output logic        ldAddr,
    output logic [2:0]  selAddr,
    output logic        ldImage,
    output logic [2:0]  selImage,
    output logic        ldFilter,
    output logic [1:0]  selFilter,
    output logic        done,
    output logic        pix_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [18:0] pix_count
);

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StFilter, StEmit} state_e;

    localparam logic [18:0] LastPix   = 19'(LENGTH * WIDTH - 1);
    localparam logic [2:0]  DrainLast = 3'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [18:0] pix_count_q, pix_count_d;
    logic        frame_done_q, frame_done_d;
    // Delay line of {ldAddr, selAddr}; the last stage lines up with RAM data arrival.
    logic [3:0]  dl_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pix_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pix_count_q  <= pix_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= {ldAddr, selAddr};
            for (int i = 1; i < RD_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pix_count_d  = pix_count_q;
        frame_done_d = 1'b0;
        ldAddr       = 1'b0;
        selAddr      = 3'd0;
        ldImage      = 1'b0;
        selImage     = 3'd0;
        ldFilter     = 1'b0;
        selFilter    = 2'd0;
        done         = 1'b0;
        pix_valid    = 1'b0;
        busy         = (state_q != StIdle);
        frame_done   = frame_done_q;
        pix_count    = pix_count_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StFetch;
                    cnt_d       = 3'd0;
                    pix_count_d = '0;
                end
            end
            StFetch: begin
                ldAddr  = 1'b1;
                selAddr = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = StDrain;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StFilter;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StFilter: begin
                ldFilter  = 1'b1;
                selFilter = cnt_q[1:0];
                if (cnt_q == 3'd3) begin
                    state_d = StEmit;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StEmit: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    done  = 1'b1;
                    cnt_d = 3'd0;
                    if (pix_count_q == LastPix) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d     = StFetch;
                        pix_count_d = pix_count_q + 19'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Captures only run while the address schedule is in flight; stale entries are masked.
        if (state_q == StFetch || state_q == StDrain) begin
            {ldImage, selImage} = dl_q[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Directed bench for median_seq_ctrl on a 4x3 frame; RD_LAT=2 main instance plus RD_LAT=1/3 copies.
module tb_median_seq_ctrl;

    logic clk = 1'b0;
    logic rst, start, pix_ready;
    always #5 clk = ~clk;

    logic        ld_addr, ld_image, ld_filter, done, pix_valid, busy, frame_done;
    logic [2:0]  sel_addr, sel_image;
    logic [1:0]  sel_filter;
    logic [18:0] pix_count;

    logic        l1_ld_addr, l1_ld_image, l1_ld_filter, l1_done, l1_pix_valid, l1_busy;
    logic        l1_frame_done;
    logic [2:0]  l1_sel_addr, l1_sel_image;
    logic [1:0]  l1_sel_filter;
    logic [18:0] l1_pix_count;

    logic        l3_ld_addr, l3_ld_image, l3_ld_filter, l3_done, l3_pix_valid, l3_busy;
    logic        l3_frame_done;
    logic [2:0]  l3_sel_addr, l3_sel_image;
    logic [1:0]  l3_sel_filter;
    logic [18:0] l3_pix_count;

    median_seq_ctrl #(.LENGTH(4), .WIDTH(3), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pix_ready(pix_ready),
        .ldAddr(ld_addr), .selAddr(sel_addr), .ldImage(ld_image), .selImage(sel_image),
        .ldFilter(ld_filter), .selFilter(sel_filter), .done(done), .pix_valid(pix_valid),
        .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
    );

    median_seq_ctrl #(.LENGTH(4), .WIDTH(3), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .pix_ready(pix_ready),
        .ldAddr(l1_ld_addr), .selAddr(l1_sel_addr), .ldImage(l1_ld_image),
        .selImage(l1_sel_image), .ldFilter(l1_ld_filter), .selFilter(l1_sel_filter),
        .done(l1_done), .pix_valid(l1_pix_valid), .busy(l1_busy),
        .frame_done(l1_frame_done), .pix_count(l1_pix_count)
    );

    median_seq_ctrl #(.LENGTH(4), .WIDTH(3), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .pix_ready(pix_ready),
        .ldAddr(l3_ld_addr), .selAddr(l3_sel_addr), .ldImage(l3_ld_image),
        .selImage(l3_sel_image), .ldFilter(l3_ld_filter), .selFilter(l3_sel_filter),
        .done(l3_done), .pix_valid(l3_pix_valid), .busy(l3_busy),
        .frame_done(l3_frame_done), .pix_count(l3_pix_count)
    );

    int total = 0;
    int bad   = 0;

    // Hand-written schedule for RD_LAT=2, indexed by cycle 0..13 after the start edge.
    int exp_sa [14] = '{0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 1};
    int exp_si [14] = '{0, 0, 0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0};
    int exp_lf [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp_sf [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0};
    int exp_dn [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [32:0] got;
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        tick();
        tick();
        got = {ld_addr, sel_addr, ld_image, sel_image, ld_filter, sel_filter, done, pix_valid,
               busy, frame_done, pix_count[10:0]};
        total++;
        if (got !== 33'd0 || pix_count !== 19'd0) begin
            bad++;
            $display("FAIL reset_main: got %h want 0 (pix_count %0d)", got, pix_count);
        end
        got = {l1_ld_addr, l1_sel_addr, l1_ld_image, l1_sel_image, l1_ld_filter, l1_sel_filter,
               l1_done, l1_pix_valid, l1_busy, l1_frame_done, l1_pix_count[10:0]};
        total++;
        if (got !== 33'd0) begin
            bad++;
            $display("FAIL reset_lat1: got %h want 0", got);
        end
        got = {l3_ld_addr, l3_sel_addr, l3_ld_image, l3_sel_image, l3_ld_filter, l3_sel_filter,
               l3_done, l3_pix_valid, l3_busy, l3_frame_done, l3_pix_count[10:0]};
        total++;
        if (got !== 33'd0) begin
            bad++;
            $display("FAIL reset_lat3: got %h want 0", got);
        end
        rst = 1'b0;
        pix_ready = 1'b1;
        tick();
        tick();
        got = {ld_addr, sel_addr, ld_image, sel_image, ld_filter, sel_filter, done, pix_valid,
               busy, frame_done, pix_count[10:0]};
        total++;
        if (got !== 33'd0) begin
            bad++;
            $display("FAIL idle_no_start: got %h want 0", got);
        end
    endtask

    task automatic test_pixel_schedule();
        logic [12:0] got, want;
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) tick();
            got  = {ld_addr, sel_addr, ld_image, sel_image, ld_filter, sel_filter, done, pix_valid};
            want = {exp_sa[c] != 0, 3'(exp_sa[c]), exp_si[c] != 0, 3'(exp_si[c]),
                    exp_lf[c] != 0, 2'(exp_sf[c]), exp_dn[c] != 0, exp_dn[c] != 0};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sched cycle %0d: got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_frame();
        int ndone = 0, nfd = 0, fd_cyc = -1, last_done = -1;
        int busy_after = 0, consec = 0;
        logic prev_pv = 1'b0, prev_dn = 1'b0;
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (done) begin
                total++;
                if (pix_count !== 19'(ndone)) begin
                    bad++;
                    $display("FAIL frame_pix_count: got %0d want %0d", pix_count, ndone);
                end
                ndone++;
                last_done = cyc;
            end
            if (frame_done) begin
                nfd++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
            if (fd_cyc >= 0 && busy) busy_after++;
            if ((pix_valid && prev_pv) || (done && prev_dn)) consec++;
            prev_pv = pix_valid;
            prev_dn = done;
            tick();
        end
        total++;
        if (ndone != 12) begin
            bad++;
            $display("FAIL frame_done_count: got %0d want 12", ndone);
        end
        total++;
        if (nfd != 1 || fd_cyc != last_done + 1) begin
            bad++;
            $display("FAIL frame_done_pulse: got %0d pulses at %0d want 1 at %0d",
                     nfd, fd_cyc, last_done + 1);
        end
        total++;
        if (busy_after != 0 || fd_cyc < 0) begin
            bad++;
            $display("FAIL busy_after_frame: got %0d busy cycles want 0", busy_after);
        end
        total++;
        if (consec != 0) begin
            bad++;
            $display("FAIL back_to_back_valid: got %0d repeats want 0", consec);
        end
        total++;
        if (pix_count !== 19'd11) begin
            bad++;
            $display("FAIL frame_final_count: got %0d want 11", pix_count);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        logic [32:0] got, want;
        do_reset();
        pix_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!pix_valid && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (!pix_valid) begin
            bad++;
            $display("FAIL stall_reach_emit: got pix_valid=0 want 1 within 40 cycles");
            return;
        end
        want = {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 19'd0};
        for (int i = 0; i < 7; i++) begin
            got = {pix_valid, done, ld_addr, sel_addr, ld_image, sel_image, ld_filter, sel_filter,
                   busy, pix_count};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stall_hold %0d: got %h want %h", i, got, want);
            end
            tick();
        end
        pix_ready = 1'b1;
        #1;
        total++;
        if ({pix_valid, done} !== 2'b11 || pix_count !== 19'd0) begin
            bad++;
            $display("FAIL stall_release: got valid/done %b count %0d want 11 count 0",
                     {pix_valid, done}, pix_count);
        end
        tick();
        pix_ready = 1'b0;
        #1;
        total++;
        if ({pix_valid, done, ld_addr, sel_addr} !== 6'b001001 || pix_count !== 19'd1) begin
            bad++;
            $display("FAIL stall_next_pixel: got %b count %0d want 001001 count 1",
                     {pix_valid, done, ld_addr, sel_addr}, pix_count);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [32:0] got;
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!(ld_image && !ld_addr && pix_count == 19'd4) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (!(ld_image && !ld_addr && pix_count == 19'd4)) begin
            bad++;
            $display("FAIL mid_reach_drain: got no drain of pixel 4 want one within 200 cycles");
            return;
        end
        #2;
        rst = 1'b1;
        #1;
        got = {ld_addr, sel_addr, ld_image, sel_image, ld_filter, sel_filter, done, pix_valid,
               busy, frame_done, pix_count[10:0]};
        total++;
        if (got !== 33'd0 || pix_count !== 19'd0) begin
            bad++;
            $display("FAIL mid_reset_async: got %h count %0d want 0", got, pix_count);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({done, frame_done, busy, ld_addr} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_idle: got %b want 0000", {done, frame_done, busy, ld_addr});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({busy, ld_addr, sel_addr} !== 5'b11001 || pix_count !== 19'd0) begin
            bad++;
            $display("FAIL mid_restart: got %b count %0d want 11001 count 0",
                     {busy, ld_addr, sel_addr}, pix_count);
        end
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (!done || pix_count !== 19'd0) begin
            bad++;
            $display("FAIL mid_restart_first_done: got done=%b count %0d want 1 count 0",
                     done, pix_count);
        end
    endtask

    task automatic test_start_held();
        int exp_idx = 0, nfd = 0, glitch = 0;
        logic check_next = 1'b0;
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 320; cyc++) begin
            if (check_next) begin
                total++;
                if ({busy, ld_addr, sel_addr} !== 5'b11001 || pix_count !== 19'd0) begin
                    bad++;
                    $display("FAIL held_new_frame: got %b count %0d want 11001 count 0",
                             {busy, ld_addr, sel_addr}, pix_count);
                end
                check_next = 1'b0;
            end
            if (done) begin
                total++;
                if (pix_count !== 19'(exp_idx)) begin
                    bad++;
                    $display("FAIL held_pix_count: got %0d want %0d", pix_count, exp_idx);
                end
                exp_idx = (exp_idx == 11) ? 0 : exp_idx + 1;
            end
            if (frame_done) begin
                nfd++;
                check_next = 1'b1;
            end
            if (!busy && !frame_done) glitch++;
            tick();
        end
        start = 1'b0;
        total++;
        if (nfd != 2 || glitch != 0) begin
            bad++;
            $display("FAIL held_frames: got %0d frames %0d idle gaps want 2 frames 0 gaps",
                     nfd, glitch);
        end
    endtask

    task automatic test_lat_sweep();
        int a1 [6], i1 [6], a3 [6], i3 [6];
        int d1 = 0, d3 = 0, s1 = 0, s3 = 0;
        for (int k = 0; k < 6; k++) begin
            a1[k] = 0; i1[k] = 0; a3[k] = 0; i3[k] = 0;
        end
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (l1_ld_addr && a1[l1_sel_addr] == 0) a1[l1_sel_addr] = cyc;
            if (l1_ld_image && i1[l1_sel_image] == 0) i1[l1_sel_image] = cyc;
            if (l3_ld_addr && a3[l3_sel_addr] == 0) a3[l3_sel_addr] = cyc;
            if (l3_ld_image && i3[l3_sel_image] == 0) i3[l3_sel_image] = cyc;
            if (l1_done && d1 == 0) d1 = cyc;
            if (l3_done && d3 == 0) d3 = cyc;
            if (cyc > 1 && l1_ld_addr && l1_sel_addr == 3'd1 && s1 == 0) s1 = cyc;
            if (cyc > 1 && l3_ld_addr && l3_sel_addr == 3'd1 && s3 == 0) s3 = cyc;
            tick();
        end
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (a1[k] != k || i1[k] - a1[k] != 1) begin
                bad++;
                $display("FAIL lat1_slot%0d: got addr@%0d image@%0d want addr@%0d image@%0d",
                         k, a1[k], i1[k], k, k + 1);
            end
            total++;
            if (a3[k] != k || i3[k] - a3[k] != 3) begin
                bad++;
                $display("FAIL lat3_slot%0d: got addr@%0d image@%0d want addr@%0d image@%0d",
                         k, a3[k], i3[k], k, k + 3);
            end
        end
        total++;
        if (d1 != 11 || s1 - 1 != 11) begin
            bad++;
            $display("FAIL lat1_period: got done@%0d period %0d want done@11 period 11",
                     d1, s1 - 1);
        end
        total++;
        if (d3 != 13 || s3 - 1 != 13) begin
            bad++;
            $display("FAIL lat3_period: got done@%0d period %0d want done@13 period 13",
                     d3, s3 - 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        test_reset();
        test_pixel_schedule();
        test_frame();
        test_stall();
        test_reset_mid();
        test_start_held();
        test_lat_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_seq_ctrl.md
# median_seq_ctrl

Sequencing controller for the median-filter datapath unit. It steps the datapath through each pixel of a frame in order: five dual-port RAM address loads, five window-register captures aligned to the RAM read latency, four comparator stages, and a result handshake to the downstream writer. Its `done` pulse advances the datapath's row/column counters. It sits between the top-level frame trigger and the datapath, and drives every datapath control input.

## Interface
- `LENGTH`, 480: pixels per row; the column wrap point.
- `WIDTH`, 640: rows per frame.
- `RD_LAT`, 2: cycles from `selAddr=k` until RAM data for slot k is valid (address register plus RAM register). Legal values are 1..3.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `pix_ready` in 1: downstream accepts the filtered pixel.
- `ldAddr` out 1: address-register load enable.
- `selAddr` out 3: address slot, 1..5; 0 when idle.
- `ldImage` out 1: window-register load enable.
- `selImage` out 3: window slot, 1..5; 0 when idle.
- `ldFilter` out 1: comparator stage enable.
- `selFilter` out 2: comparator stage, 0..3.
- `done` out 1: one-cycle pixel-advance pulse to the datapath.
- `pix_valid` out 1: filtered pixel available.
- `busy` out 1: high from FETCH entry until the frame completes.
- `frame_done` out 1: one-cycle pulse after the last pixel.
- `pix_count` out 19: index of the current pixel, 0..LENGTH*WIDTH-1.

## Operation
- States:
  - IDLE
  - FETCH: 5 cycles, phase counter 0..4.
  - DRAIN: RD_LAT cycles.
  - FILTER: 4 cycles.
  - EMIT: waits for handshake.
- IDLE -> FETCH when `start`=1. `pix_count` clears to 0 on this transition. `start` in any other state is ignored.
- FETCH:
  - `ldAddr`=1 and `selAddr`=phase+1, so slots 1,2,3,4,5 go out on consecutive cycles.
  - After phase 4, go to DRAIN.
- Image capture is a delay line on the address schedule:
  - `ldImage`/`selImage` in cycle t equal `ldAddr`/`selAddr` from cycle t-RD_LAT.
  - Slot k is captured RD_LAT cycles after it is addressed.
  - The delay line spans FETCH and DRAIN. It is 0 in every other state.
- DRAIN -> FILTER after RD_LAT cycles, which is when slot 5 has been captured.
- FILTER: `ldFilter`=1 and `selFilter`=0,1,2,3 on consecutive cycles, then go to EMIT.
- EMIT:
  - `pix_valid`=1 and held until `pix_ready`=1.
  - In the handshake cycle, `done`=1 for exactly that cycle.
- Leaving EMIT:
  - If `pix_count`==LENGTH*WIDTH-1: go to IDLE, pulse `frame_done` in the next cycle, and drop `busy` in that same cycle.
  - Otherwise: increment `pix_count` and go to FETCH.
- Arithmetic: LENGTH*WIDTH-1 is compared as a 19-bit constant (307199 fits). `pix_count` never exceeds it and has no wrap beyond it.
- All load/select outputs are 0 whenever their state does not drive them, so the datapath sees select 0, a no-op.

## Timing
- Reset values: every output is 0, `pix_count`=0, state is IDLE, the delay line is cleared.
- Reset during a frame returns to IDLE immediately (asynchronous). No `done` or `frame_done` is produced. The controller does not restore datapath row/column; the top level resets both.
- Cycle numbering: `start` sampled high at edge 0.
  - Cycles 1..5: `selAddr`=1..5.
  - Cycles 1+RD_LAT..5+RD_LAT: `selImage`=1..5.
  - Cycles 6+RD_LAT..9+RD_LAT: `selFilter`=0..3.
  - Cycle 10+RD_LAT: `pix_valid`=1.
- Per-pixel period with `pix_ready` tied high is 10+RD_LAT cycles (12 at default). The next FETCH starts the cycle after `done`.
- `pix_valid` and `done` are never high for two consecutive cycles when `pix_ready` is tied high.
- `pix_ready` held low stalls in EMIT indefinitely. `pix_valid` stays high, no other control toggles, and `pix_count` is stable.
- `pix_ready` high outside EMIT has no effect.
- `start` high during `frame_done` (in IDLE) starts a new frame in the next cycle.

## Test plan
- Reset, then `start` pulse at cycle 0, `pix_ready`=1, RD_LAT=2 → `selAddr` 1..5 in cycles 1-5; `selImage` 1..5 in cycles 3-7; `selFilter` 0..3 in cycles 8-11; `done` in cycle 12; `selAddr`=1 again in cycle 13.
- LENGTH=4, WIDTH=3, `pix_ready`=1 → exactly 12 `done` pulses, `pix_count` 0..11, `frame_done` one cycle after the 12th `done`, `busy` low from then on.
- Hold `pix_ready`=0 for 7 cycles in EMIT → `pix_valid` held 8 cycles, one `done` in the release cycle, `pix_count` unchanged until then.
- Assert `rst` during DRAIN of pixel 5 → all outputs 0 immediately, IDLE. A subsequent `start` restarts at `pix_count`=0.
- `start` held high throughout a frame → no restart or glitch mid-frame; a new frame begins the cycle after `frame_done`.
- Sweep RD_LAT=1 and RD_LAT=3 → `selImage`=k trails `selAddr`=k by exactly RD_LAT cycles; per-pixel period is 11 and 13 cycles respectively.
